soin_bpredictor_update: RTL and testbench
=========================================

SOIN_BPREDICTOR_UPDATE -- requirements
Module: soin_bpredictor_update

Interface
REQ-001 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset.
REQ-003 ex_valid  input  1  a resolved control-transfer instruction is presented this cycle.
REQ-004 ex_ready  output  1  queue can accept; a resolve is taken when ex_valid & ex_ready.
REQ-005 ex_PC  input  32  PC of the resolved instruction.
REQ-006 ex_target  input  32  actual taken target.
REQ-007 ex_dir  input  1  actual direction (1 = taken).
REQ-008 ex_p_dir  input  1  direction predicted at fetch.
REQ-009 ex_meta  input  `BP_META_WIDTH  fetch meta: [7:0] lookup index, [15:8] counter byte read at fetch.
REQ-010 soin_bpredictor_stall  input  1  predictor cannot accept a write this cycle.
REQ-011 execute_bpredictor_update  output  1  write strobe to the predictor.
REQ-012 execute_bpredictor_PC / _target  output  32 each  PC and target of the entry being written.
REQ-013 execute_bpredictor_dir / _miss  output  1 each  actual direction and mispredict flag of that entry.
REQ-014 execute_bpredictor_meta  output  `BP_META_WIDTH  [7:0] index, [15:8] new counter byte, [19:16] byte enable; higher bits zero.
REQ-015 fetch_redirect  output  1  one-cycle mispredict redirect pulse.
REQ-016 fetch_redirect_PC  output  32  correct next PC for the redirect.

Function
REQ-017 Accepted resolves SHALL enter a 4-entry FIFO in order; each entry holds PC, target, dir, miss, index, new byte, byte enable.
REQ-018 Counter select: c = bits [2*PC[3:2]+1 : 2*PC[3:2]] of the counter byte; byte enable = one-hot of PC[5:4].
REQ-019 New counter: ex_dir=1 -> min(c+1, 3); ex_dir=0 -> max(c-1, 0); all other 3 counters in the byte SHALL be unchanged.
REQ-020 Forwarding: if the newest valid FIFO entry (or the entry being enqueued in the previous cycle) has the same index and byte enable, its new byte SHALL replace ex_meta[15:8] as the base.
REQ-021 miss = ex_dir XOR ex_p_dir, or (ex_dir & ex_p_dir & ex_target != predicted-target mismatch flagged by ex_meta bit 20).
REQ-022 Head drain: execute_bpredictor_update = FIFO non-empty & ~soin_bpredictor_stall; the head pops in the same cycle; outputs are registered from the head, so drain latency is 1 cycle minimum after enqueue.
REQ-023 ex_ready = 0 when 4 entries are held and no pop occurs this cycle; simultaneous push and pop at full SHALL be accepted.
REQ-024 Simultaneous push/pop on an empty FIFO SHALL NOT bypass; the entry is written the next cycle.
REQ-025 fetch_redirect SHALL pulse for exactly 1 cycle, the cycle after an accepted resolve with miss=1; fetch_redirect_PC = ex_dir ? ex_target : ex_PC+4 (32-bit wrap).
REQ-026 Redirect SHALL NOT depend on FIFO occupancy or stall.
REQ-027 Pointers SHALL be 2-bit wrap-around with a 3-bit count; count never exceeds 4.

Reset
REQ-028 During reset: FIFO empty, ex_ready=1, execute_bpredictor_update=0, fetch_redirect=0, all data outputs 0.
REQ-029 Reset mid-operation SHALL discard all queued entries; no write strobe in the cycle after deassertion.

Structure
REQ-030 Meta field offsets, FIFO depth (4) and counter width (2) SHALL live in the shared soin header/package next to `BP_META_WIDTH.
REQ-031 The saturating counter-byte update SHALL be one sub-module, soin_bpredictor_ctr_update (byte, sel, dir -> new byte).

Verification
REQ-032 PC=0x1000, byte=0x00, dir=1 -> meta index 0x00, byte 0x01, be 0001; update on cycle after enqueue.
REQ-033 PC=0x103C, byte=0xC0, dir=1, p_dir=1 -> byte stays 0xC0 (saturate), be 1000, miss=0, no redirect.
REQ-034 PC=0x2000, dir=0, p_dir=1 -> fetch_redirect one cycle, fetch_redirect_PC=0x2004, miss=1.
REQ-035 Two back-to-back resolves same PC, stale byte 0x00, dir=1 -> second write byte 0x02.
REQ-036 Hold stall=1, push 5 resolves -> ex_ready low after 4th; release stall -> 4 writes in order, then 5th.
REQ-037 Assert reset with 3 entries queued -> no writes after release, ex_ready=1.

Source files
------------

// File: rtl/soin_bpredictor_pkg.sv
// Shared definitions for the branch-predictor update path: meta field layout,
// queue geometry, counter width and the queued-entry record.
package soin_bpredictor_pkg;

   // Fetch/update meta word layout.
   localparam int BP_META_WIDTH  = 32;
   localparam int META_IDX_LSB   = 0;
   localparam int META_IDX_W     = 8;
   localparam int META_CTR_LSB   = 8;
   localparam int META_CTR_W     = 8;
   localparam int META_BE_LSB    = 16;
   localparam int META_BE_W      = 4;
   localparam int META_TMISS_BIT = 20;
   localparam int META_USED_W    = META_BE_LSB + META_BE_W;

   // Saturating counters packed four to a byte.
   localparam int CTR_WIDTH      = 2;

   // Update queue geometry.
   localparam int FIFO_DEPTH     = 4;
   localparam int PTR_W          = $clog2(FIFO_DEPTH);
   localparam int CNT_W          = PTR_W + 1;

   // One pending predictor write.
   typedef struct packed {
      logic [31:0]           pc;
      logic [31:0]           target;
      logic                  dir;
      logic                  miss;
      logic [META_IDX_W-1:0] idx;
      logic [META_CTR_W-1:0] new_byte;
      logic [META_BE_W-1:0]  be;
   } bp_entry_t;

   // Byte lane within the predictor row holding this PC's counter.
   function automatic logic [META_BE_W-1:0] be_onehot(input logic [1:0] bsel);
      be_onehot = META_BE_W'(1) << bsel;
   endfunction

endpackage

// File: rtl/soin_bpredictor_ctr_update.sv
// Updates one 2-bit saturating counter inside a counter byte; the other three
// counters pass through untouched.
module soin_bpredictor_ctr_update
   import soin_bpredictor_pkg::*;
(
   input  logic [META_CTR_W-1:0] ctr_byte,
   input  logic [1:0]            sel,
   input  logic                  dir,
   output logic [META_CTR_W-1:0] new_byte
);

   logic [CTR_WIDTH-1:0] ctr_cur;
   logic [CTR_WIDTH-1:0] ctr_nxt;

   // Saturating increment on taken, saturating decrement on not-taken.
   // NOTE: every output of a combinational block gets a value on every path
   // (defaults first) so no latch is inferred.
   always_comb begin
      ctr_cur  = ctr_byte[{sel, 1'b0} +: CTR_WIDTH];
      ctr_nxt  = ctr_cur;
      new_byte = ctr_byte;
      if (dir) begin
         if (ctr_cur != '1) ctr_nxt = ctr_cur + CTR_WIDTH'(1);
      end else begin
         if (ctr_cur != '0) ctr_nxt = ctr_cur - CTR_WIDTH'(1);
      end
      new_byte[{sel, 1'b0} +: CTR_WIDTH] = ctr_nxt;
   end

endmodule

// File: rtl/soin_bpredictor_update.sv
// Collects resolved branches from execute, computes the new counter byte
// (forwarding from the newest queued write to the same byte), queues the
// writes in a small FIFO drained toward the predictor, and raises a one-cycle
// fetch redirect on mispredicts independent of the queue.
module soin_bpredictor_update
   import soin_bpredictor_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     ex_valid,
   output logic                     ex_ready,
   input  logic [31:0]              ex_PC,
   input  logic [31:0]              ex_target,
   input  logic                     ex_dir,
   input  logic                     ex_p_dir,
   input  logic [BP_META_WIDTH-1:0] ex_meta,
   input  logic                     soin_bpredictor_stall,
   output logic                     execute_bpredictor_update,
   output logic [31:0]              execute_bpredictor_PC,
   output logic [31:0]              execute_bpredictor_target,
   output logic                     execute_bpredictor_dir,
   output logic                     execute_bpredictor_miss,
   output logic [BP_META_WIDTH-1:0] execute_bpredictor_meta,
   output logic                     fetch_redirect,
   output logic [31:0]              fetch_redirect_PC
);

   bp_entry_t             fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q;
   logic [PTR_W-1:0]      rd_ptr_q;
   logic [CNT_W-1:0]      count_q;

   logic                  push;
   logic                  pop;
   logic                  not_empty;
   logic [PTR_W-1:0]      newest_ptr;
   bp_entry_t             newest;
   bp_entry_t             head;
   bp_entry_t             enq;
   logic [META_IDX_W-1:0] idx;
   logic [META_BE_W-1:0]  be;
   logic                  fwd_hit;
   logic [META_CTR_W-1:0] base_byte;
   logic [META_CTR_W-1:0] upd_byte;
   logic                  miss;

   // Meta bits this block never consumes on the input side.
   logic unused_meta;
   assign unused_meta = ^{ex_meta[BP_META_WIDTH-1:META_TMISS_BIT+1],
                          ex_meta[META_TMISS_BIT-1:META_BE_LSB]};

   // Handshake: a pop frees a slot in the same cycle, so full+pop still accepts.
   always_comb begin
      not_empty = (count_q != '0);
      pop       = not_empty & ~soin_bpredictor_stall;
      ex_ready  = (count_q != CNT_W'(FIFO_DEPTH)) | pop;
      push      = ex_valid & ex_ready;
   end

   // Counter-byte base selection with forwarding from the newest queued entry.
   always_comb begin
      idx        = ex_meta[META_IDX_LSB +: META_IDX_W];
      be         = be_onehot(ex_PC[5:4]);
      newest_ptr = wr_ptr_q - PTR_W'(1);
      newest     = fifo_mem[newest_ptr];
      fwd_hit    = not_empty && (newest.idx == idx) && (newest.be == be);
      base_byte  = fwd_hit ? newest.new_byte : ex_meta[META_CTR_LSB +: META_CTR_W];
      miss       = (ex_dir ^ ex_p_dir) | (ex_dir & ex_p_dir & ex_meta[META_TMISS_BIT]);
   end

   soin_bpredictor_ctr_update u_ctr_update (
      .ctr_byte (base_byte),
      .sel      (ex_PC[3:2]),
      .dir      (ex_dir),
      .new_byte (upd_byte)
   );

   // Assemble the entry to enqueue.
   always_comb begin
      enq.pc       = ex_PC;
      enq.target   = ex_target;
      enq.dir      = ex_dir;
      enq.miss     = miss;
      enq.idx      = idx;
      enq.new_byte = upd_byte;
      enq.be       = be;
   end

   // Queue pointers and occupancy; reset discards everything queued.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Queue storage write.
   // NOTE: storage is not reset; occupancy gates every read, so stale contents
   // are never observed.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= enq;
   end

   // Predictor write port driven straight from the registered head entry.
   always_comb begin
      head                      = fifo_mem[rd_ptr_q];
      execute_bpredictor_update = pop;
      execute_bpredictor_PC     = '0;
      execute_bpredictor_target = '0;
      execute_bpredictor_dir    = 1'b0;
      execute_bpredictor_miss   = 1'b0;
      execute_bpredictor_meta   = '0;
      if (not_empty) begin
         execute_bpredictor_PC     = head.pc;
         execute_bpredictor_target = head.target;
         execute_bpredictor_dir    = head.dir;
         execute_bpredictor_miss   = head.miss;
         execute_bpredictor_meta   = {{(BP_META_WIDTH-META_USED_W){1'b0}},
                                      head.be, head.new_byte, head.idx};
      end
   end

   // One-cycle redirect for every accepted mispredict, independent of drain.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_redirect    <= 1'b0;
         fetch_redirect_PC <= '0;
      end else begin
         fetch_redirect <= push & miss;
         if (push & miss) fetch_redirect_PC <= ex_dir ? ex_target : ex_PC + 32'd4;
      end
   end

endmodule

// File: tb/tb_soin_bpredictor_update.sv
// Directed bench for the branch-predictor update queue and redirect logic.
module tb_soin_bpredictor_update;

   logic        clk;
   logic        reset;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] ex_PC;
   logic [31:0] ex_target;
   logic        ex_dir;
   logic        ex_p_dir;
   logic [31:0] ex_meta;
   logic        soin_bpredictor_stall;
   logic        execute_bpredictor_update;
   logic [31:0] execute_bpredictor_PC;
   logic [31:0] execute_bpredictor_target;
   logic        execute_bpredictor_dir;
   logic        execute_bpredictor_miss;
   logic [31:0] execute_bpredictor_meta;
   logic        fetch_redirect;
   logic [31:0] fetch_redirect_PC;

   int n_run  = 0;
   int n_fail = 0;

   soin_bpredictor_update dut (
      .clk                       (clk),
      .reset                     (reset),
      .ex_valid                  (ex_valid),
      .ex_ready                  (ex_ready),
      .ex_PC                     (ex_PC),
      .ex_target                 (ex_target),
      .ex_dir                    (ex_dir),
      .ex_p_dir                  (ex_p_dir),
      .ex_meta                   (ex_meta),
      .soin_bpredictor_stall     (soin_bpredictor_stall),
      .execute_bpredictor_update (execute_bpredictor_update),
      .execute_bpredictor_PC     (execute_bpredictor_PC),
      .execute_bpredictor_target (execute_bpredictor_target),
      .execute_bpredictor_dir    (execute_bpredictor_dir),
      .execute_bpredictor_miss   (execute_bpredictor_miss),
      .execute_bpredictor_meta   (execute_bpredictor_meta),
      .fetch_redirect            (fetch_redirect),
      .fetch_redirect_PC         (fetch_redirect_PC)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ex_valid  = 1'b0;
      ex_PC     = '0;
      ex_target = '0;
      ex_dir    = 1'b0;
      ex_p_dir  = 1'b0;
      ex_meta   = '0;
   endtask

   task automatic drive(input logic [31:0] pc, input logic [31:0] tgt,
                        input logic dir, input logic pdir,
                        input logic [7:0] idx, input logic [7:0] cbyte,
                        input logic tmiss);
      ex_valid  = 1'b1;
      ex_PC     = pc;
      ex_target = tgt;
      ex_dir    = dir;
      ex_p_dir  = pdir;
      ex_meta   = {11'h0, tmiss, 4'h0, cbyte, idx};
   endtask

   task automatic test_reset();
      reset = 1'b0;
      soin_bpredictor_stall = 1'b0;
      idle();
      #2;
      n_run++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %0b want 1", ex_ready); end
      n_run++; if (execute_bpredictor_update !== 1'b0) begin n_fail++; $display("FAIL rst_update: got %0b want 0", execute_bpredictor_update); end
      n_run++; if (fetch_redirect !== 1'b0) begin n_fail++; $display("FAIL rst_redirect: got %0b want 0", fetch_redirect); end
      n_run++; if (fetch_redirect_PC !== 32'h0) begin n_fail++; $display("FAIL rst_redirect_pc: got %h want 0", fetch_redirect_PC); end
      n_run++; if (execute_bpredictor_meta !== 32'h0) begin n_fail++; $display("FAIL rst_meta: got %h want 0", execute_bpredictor_meta); end
      n_run++; if (execute_bpredictor_PC !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h want 0", execute_bpredictor_PC); end
      @(negedge clk);
      reset = 1'b1;
      cyc();
      #3;
      n_run++; if (execute_bpredictor_update !== 1'b0) begin n_fail++; $display("FAIL rst_rel_update: got %0b want 0", execute_bpredictor_update); end
      n_run++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL rst_rel_ready: got %0b want 1", ex_ready); end
   endtask

   // PC 0x1000, byte 0x00, taken: counter 0 -> 1, lane 0.
   task automatic test_basic_write();
      cyc();
      drive(32'h0000_1000, 32'h0000_2000, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
      #3;
      n_run++; if (execute_bpredictor_update !== 1'b0) begin n_fail++; $display("FAIL basic_no_bypass: got %0b want 0", execute_bpredictor_update); end
      n_run++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %0b want 1", ex_ready); end
      cyc();
      idle();
      #3;
      n_run++; if (execute_bpredictor_update !== 1'b1) begin n_fail++; $display("FAIL basic_update: got %0b want 1", execute_bpredictor_update); end
      n_run++; if (execute_bpredictor_meta !== 32'h0001_0100) begin n_fail++; $display("FAIL basic_meta: got %h want 00010100", execute_bpredictor_meta); end
      n_run++; if (execute_bpredictor_PC !== 32'h0000_1000) begin n_fail++; $display("FAIL basic_pc: got %h want 00001000", execute_bpredictor_PC); end
      n_run++; if (execute_bpredictor_target !== 32'h0000_2000) begin n_fail++; $display("FAIL basic_target: got %h want 00002000", execute_bpredictor_target); end
      n_run++; if (execute_bpredictor_dir !== 1'b1) begin n_fail++; $display("FAIL basic_dir: got %0b want 1", execute_bpredictor_dir); end
      n_run++; if (execute_bpredictor_miss !== 1'b0) begin n_fail++; $display("FAIL basic_miss: got %0b want 0", execute_bpredictor_miss); end
      n_run++; if (fetch_redirect !== 1'b0) begin n_fail++; $display("FAIL basic_redirect: got %0b want 0", fetch_redirect); end
      cyc();
      #3;
      n_run++; if (execute_bpredictor_update !== 1'b0) begin n_fail++; $display("FAIL basic_drained: got %0b want 0", execute_bpredictor_update); end
   endtask

   // PC 0x103C: counter 3 in lane 3, already 3 -> saturates.
   task automatic test_saturate();
      cyc();
      drive(32'h0000_103C, 32'h0000_3000, 1'b1, 1'b1, 8'h05, 8'hC0, 1'b0);
      cyc();
      idle();
      #3;
      n_run++; if (execute_bpredictor_update !== 1'b1) begin n_fail++; $display("FAIL sat_update: got %0b want 1", execute_bpredictor_update); end
      n_run++; if (execute_bpredictor_meta !== 32'h0008_C005) begin n_fail++; $display("FAIL sat_meta: got %h want 0008c005", execute_bpredictor_meta); end
      n_run++; if (execute_bpredictor_miss !== 1'b0) begin n_fail++; $display("FAIL sat_miss: got %0b want 0", execute_bpredictor_miss); end
      n_run++; if (fetch_redirect !== 1'b0) begin n_fail++; $display("FAIL sat_redirect: got %0b want 0", fetch_redirect); end
      cyc();
   endtask

   // Not-taken mispredict: redirect to PC+4, counter 2 -> 1.
   task automatic test_redirect();
      drive(32'h0000_2000, 32'h0000_9000, 1'b0, 1'b1, 8'h10, 8'h02, 1'b0);
      cyc();
      idle();
      #3;
      n_run++; if (fetch_redirect !== 1'b1) begin n_fail++; $display("FAIL redir_pulse: got %0b want 1", fetch_redirect); end
      n_run++; if (fetch_redirect_PC !== 32'h0000_2004) begin n_fail++; $display("FAIL redir_pc: got %h want 00002004", fetch_redirect_PC); end
      n_run++; if (execute_bpredictor_miss !== 1'b1) begin n_fail++; $display("FAIL redir_miss: got %0b want 1", execute_bpredictor_miss); end
      n_run++; if (execute_bpredictor_dir !== 1'b0) begin n_fail++; $display("FAIL redir_dir: got %0b want 0", execute_bpredictor_dir); end
      n_run++; if (execute_bpredictor_meta !== 32'h0001_0110) begin n_fail++; $display("FAIL redir_meta: got %h want 00010110", execute_bpredictor_meta); end
      cyc();
      #3;
      n_run++; if (fetch_redirect !== 1'b0) begin n_fail++; $display("FAIL redir_one_cycle: got %0b want 0", fetch_redirect); end
   endtask

   // Redirects while the predictor is stalled, including taken-target
   // mismatch and 32-bit wrap of PC+4; then drain the three entries.
   task automatic test_redirect_stalled();
      logic [31:0] v_pc  [3] = '{32'h0000_3000, 32'h0000_3100, 32'hFFFF_FFFC};
      logic [31:0] v_tgt [3] = '{32'h4444_0000, 32'h5550_0000, 32'h0000_1234};
      logic        v_dir [3] = '{1'b1, 1'b1, 1'b0};
      logic        v_pdir[3] = '{1'b0, 1'b1, 1'b1};
      logic        v_tm  [3] = '{1'b0, 1'b1, 1'b0};
      logic [31:0] v_rpc [3] = '{32'h4444_0000, 32'h5550_0000, 32'h0000_0000};
      soin_bpredictor_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(v_pc[i], v_tgt[i], v_dir[i], v_pdir[i], 8'h70 + 8'(i), 8'h00, v_tm[i]);
         cyc();
         idle();
         #3;
         n_run++; if (fetch_redirect !== 1'b1) begin n_fail++; $display("FAIL stl_redir_%0d: got %0b want 1", i, fetch_redirect); end
         n_run++; if (fetch_redirect_PC !== v_rpc[i]) begin n_fail++; $display("FAIL stl_redir_pc_%0d: got %h want %h", i, fetch_redirect_PC, v_rpc[i]); end
         n_run++; if (execute_bpredictor_update !== 1'b0) begin n_fail++; $display("FAIL stl_update_%0d: got %0b want 0", i, execute_bpredictor_update); end
         cyc();
      end
      soin_bpredictor_stall = 1'b0;
      #3;
      n_run++; if (fetch_redirect !== 1'b0) begin n_fail++; $display("FAIL stl_redir_end: got %0b want 0", fetch_redirect); end
      for (int i = 0; i < 3; i++) begin
         n_run++; if (execute_bpredictor_update !== 1'b1) begin n_fail++; $display("FAIL stl_drain_upd_%0d: got %0b want 1", i, execute_bpredictor_update); end
         n_run++; if (execute_bpredictor_PC !== v_pc[i]) begin n_fail++; $display("FAIL stl_drain_pc_%0d: got %h want %h", i, execute_bpredictor_PC, v_pc[i]); end
         n_run++; if (execute_bpredictor_miss !== 1'b1) begin n_fail++; $display("FAIL stl_drain_miss_%0d: got %0b want 1", i, execute_bpredictor_miss); end
         cyc();
         #3;
      end
      n_run++; if (execute_bpredictor_update !== 1'b0) begin n_fail++; $display("FAIL stl_drained: got %0b want 0", execute_bpredictor_update); end
   endtask

   // Two resolves to the same counter, both carrying stale byte 0x00.
   task automatic test_back_to_back();
      cyc();
      drive(32'h0000_1000, 32'h0, 1'b1, 1'b1, 8'h20, 8'h00, 1'b0);
      cyc();
      drive(32'h0000_1000, 32'h0, 1'b1, 1'b1, 8'h20, 8'h00, 1'b0);
      #3;
      n_run++; if (execute_bpredictor_meta !== 32'h0001_0120) begin n_fail++; $display("FAIL b2b_first_meta: got %h want 00010120", execute_bpredictor_meta); end
      cyc();
      idle();
      #3;
      n_run++; if (execute_bpredictor_update !== 1'b1) begin n_fail++; $display("FAIL b2b_second_upd: got %0b want 1", execute_bpredictor_update); end
      n_run++; if (execute_bpredictor_meta !== 32'h0001_0220) begin n_fail++; $display("FAIL b2b_second_meta: got %h want 00010220", execute_bpredictor_meta); end
      cyc();
   endtask

   // Fill under stall, hold the fifth, then release: push at full with pop.
   task automatic test_full();
      logic [31:0] exp_meta;
      soin_bpredictor_stall = 1'b1;
      for (int k = 0; k < 5; k++) begin
         drive(32'h0000_5000 + 32'(k * 'h40), 32'h0, 1'b1, 1'b1, 8'h40 + 8'(k), 8'h00, 1'b0);
         #3;
         n_run++; if (ex_ready !== (k < 4)) begin n_fail++; $display("FAIL full_ready_%0d: got %0b want %0b", k, ex_ready, (k < 4)); end
         if (k < 4) cyc();
      end
      cyc();
      #3;
      n_run++; if (ex_ready !== 1'b0) begin n_fail++; $display("FAIL full_hold_ready: got %0b want 0", ex_ready); end
      n_run++; if (execute_bpredictor_update !== 1'b0) begin n_fail++; $display("FAIL full_hold_upd: got %0b want 0", execute_bpredictor_update); end
      cyc();
      soin_bpredictor_stall = 1'b0;
      #1;
      n_run++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL full_pushpop_ready: got %0b want 1", ex_ready); end
      for (int j = 0; j < 5; j++) begin
         exp_meta = 32'h0001_0100 | 32'(8'h40 + 8'(j));
         n_run++; if (execute_bpredictor_update !== 1'b1) begin n_fail++; $display("FAIL full_drain_upd_%0d: got %0b want 1", j, execute_bpredictor_update); end
         n_run++; if (execute_bpredictor_meta !== exp_meta) begin n_fail++; $display("FAIL full_drain_meta_%0d: got %h want %h", j, execute_bpredictor_meta, exp_meta); end
         cyc();
         idle();
         #3;
      end
      n_run++; if (execute_bpredictor_update !== 1'b0) begin n_fail++; $display("FAIL full_drained: got %0b want 0", execute_bpredictor_update); end
   endtask

   // Reset with three entries queued discards them all.
   task automatic test_reset_midop();
      cyc();
      soin_bpredictor_stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         drive(32'h0000_6000 + 32'(k * 'h40), 32'h0, 1'b1, 1'b1, 8'h60 + 8'(k), 8'h00, 1'b0);
         cyc();
      end
      idle();
      soin_bpredictor_stall = 1'b0;
      reset = 1'b0;
      #3;
      n_run++; if (execute_bpredictor_update !== 1'b0) begin n_fail++; $display("FAIL mid_rst_upd: got %0b want 0", execute_bpredictor_update); end
      n_run++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready: got %0b want 1", ex_ready); end
      n_run++; if (execute_bpredictor_meta !== 32'h0) begin n_fail++; $display("FAIL mid_rst_meta: got %h want 0", execute_bpredictor_meta); end
      cyc();
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #3;
         n_run++; if (execute_bpredictor_update !== 1'b0) begin n_fail++; $display("FAIL mid_rel_upd_%0d: got %0b want 0", k, execute_bpredictor_update); end
         n_run++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rel_ready_%0d: got %0b want 1", k, ex_ready); end
         cyc();
      end
   endtask

   initial begin
      test_reset();
      test_basic_write();
      test_saturate();
      test_redirect();
      test_redirect_stalled();
      test_back_to_back();
      test_full();
      test_reset_midop();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
